sum_tx_sequencer: RTL

Controller that sequences the shared UART transmitter for the latch-and-sum datapath. On a send request it snapshots the two latched 4-bit operands and streams the ASCII message "A+B=SS\r\n" (hex digits) to the UART transmitter one byte at a time, using the transmitter's start/busy handshake. It sits between the operand latches/adder and the UART TX. It buffers one pending request and flags overruns.

---
 rtl/sum_tx_pkg.sv | 24 ++
 rtl/hex_ascii_enc.sv | 17 +
 rtl/sum_tx_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sum_tx_pkg.sv
// Shared types and constants for the sum message transmit sequencer.
package sum_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [7:0] PLUS   = 8'h2B;
  localparam logic [7:0] EQUALS = 8'h3D;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;

  localparam int MSG_LEN = 8;
  localparam int IDX_W   = $clog2(MSG_LEN);

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(MSG_LEN - 1);

endpackage

// File: rtl/hex_ascii_enc.sv
// Nibble to ASCII hex digit, letter case selected at elaboration.
module hex_ascii_enc #(
  parameter int UPPERCASE = 1
) (
  input  logic [3:0] i_nib,
  output logic [7:0] o_ascii
);

  localparam logic [7:0] ALPHA_BASE = (UPPERCASE != 0) ? 8'h41 : 8'h61;

  // Digits map onto '0'..'9', values 10..15 onto the letter range.
  always_comb begin
    if (i_nib < 4'd10) o_ascii = 8'h30 + {4'h0, i_nib};
    else               o_ascii = ALPHA_BASE + {4'h0, i_nib} - 8'd10;
  end

endmodule

// File: rtl/sum_tx_sequencer.sv
// Streams "A+B=SS\r\n" to a UART TX via its start/busy handshake,
// with a one-deep pending request buffer and a sticky overrun flag.
module sum_tx_sequencer
  import sum_tx_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15,
  parameter int GAP_CYCLES  = 0,
  parameter int UPPERCASE   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_req,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       seq_busy,
  output logic       overrun
);

  state_t     r_state;
  logic       r_req_q;
  logic [3:0] r_a, r_b, r_pa, r_pb;
  logic       r_pend;
  idx_t       r_idx;
  logic [7:0] r_cnt;
  logic       r_tx_start;
  logic [7:0] r_tx_data;
  logic       r_seq_busy;
  logic       r_overrun;

  logic       w_edge, w_byte_done, w_last;
  logic [3:0] w_src_a, w_src_b;
  idx_t       w_src_idx;
  logic [4:0] w_sum;
  logic [7:0] w_hex_a, w_hex_b, w_hex_sh, w_hex_sl, w_byte;

  assign w_edge      = send_req & ~r_req_q;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_byte_done = ((r_state == WAIT_ACK) && !tx_busy && (r_cnt == 8'(ACK_TIMEOUT))) ||
                       ((r_state == WAIT_DONE) && !tx_busy);

  // Operands/index the next launched byte will come from, so tx_data can
  // be registered in the same cycle tx_start is.
  always_comb begin
    w_src_a   = r_a;
    w_src_b   = r_b;
    w_src_idx = r_idx;
    if (r_state == IDLE) begin
      w_src_a   = op_a;
      w_src_b   = op_b;
      w_src_idx = '0;
    end else if (w_byte_done) begin
      if (!w_last) begin
        w_src_idx = r_idx + idx_t'(1);
      end else begin
        // A same-cycle edge is the newest request and wins over the buffer.
        w_src_a   = w_edge ? op_a : r_pa;
        w_src_b   = w_edge ? op_b : r_pb;
        w_src_idx = '0;
      end
    end
  end

  assign w_sum = {1'b0, w_src_a} + {1'b0, w_src_b};

  hex_ascii_enc #(.UPPERCASE(UPPERCASE)) u_enc_a  (.i_nib(w_src_a),            .o_ascii(w_hex_a));
  hex_ascii_enc #(.UPPERCASE(UPPERCASE)) u_enc_b  (.i_nib(w_src_b),            .o_ascii(w_hex_b));
  hex_ascii_enc #(.UPPERCASE(UPPERCASE)) u_enc_sh (.i_nib({3'b000, w_sum[4]}), .o_ascii(w_hex_sh));
  hex_ascii_enc #(.UPPERCASE(UPPERCASE)) u_enc_sl (.i_nib(w_sum[3:0]),         .o_ascii(w_hex_sl));

  // Message byte selected by position.
  always_comb begin
    w_byte = LF;
    case (w_src_idx)
      3'd0:    w_byte = w_hex_a;
      3'd1:    w_byte = PLUS;
      3'd2:    w_byte = w_hex_b;
      3'd3:    w_byte = EQUALS;
      3'd4:    w_byte = w_hex_sh;
      3'd5:    w_byte = w_hex_sl;
      3'd6:    w_byte = CR;
      default: w_byte = LF;
    endcase
  end

  // Sequencer FSM: request capture, byte handshake, gap timing, outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_req_q    <= 1'b1;
      r_a        <= '0;
      r_b        <= '0;
      r_pa       <= '0;
      r_pb       <= '0;
      r_pend     <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_seq_busy <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_req_q    <= send_req;
      r_tx_start <= 1'b0;

      // Requests arriving mid-message go to the buffer; last one wins.
      if (w_edge && (r_state != IDLE)) begin
        r_pa   <= op_a;
        r_pb   <= op_b;
        r_pend <= 1'b1;
        if (r_pend) r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_a        <= op_a;
            r_b        <= op_b;
            r_idx      <= '0;
            r_state    <= START;
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
            r_seq_busy <= 1'b1;
          end
        end
        START: begin
          r_state <= WAIT_ACK;
          r_cnt   <= '0;
        end
        WAIT_ACK: begin
          if (tx_busy)           r_state <= WAIT_DONE;
          else if (!w_byte_done) r_cnt   <= r_cnt + 8'd1;
        end
        GAP: begin
          if (r_cnt == 8'(GAP_CYCLES - 1)) begin
            r_state    <= START;
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase

      if (w_byte_done) begin
        if (!w_last) begin
          r_idx <= w_src_idx;
          if (GAP_CYCLES > 0) begin
            r_state <= GAP;
            r_cnt   <= '0;
          end else begin
            r_state    <= START;
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
          end
        end else if (r_pend || w_edge) begin
          r_a        <= w_src_a;
          r_b        <= w_src_b;
          r_idx      <= '0;
          r_pend     <= 1'b0;
          r_state    <= START;
          r_tx_start <= 1'b1;
          r_tx_data  <= w_byte;
        end else begin
          r_state    <= IDLE;
          r_seq_busy <= 1'b0;
        end
      end
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign seq_busy = r_seq_busy;
  assign overrun  = r_overrun;

endmodule
